universal_counter_param: RTL and testbench

- Parametrised successor of the 16-bit free-running binary counter.
- Adds configurable width, optional modulus, up/down direction, enable, synchronous clear, parallel load, terminal-count flags and a registered wrap pulse.
- Serves as the general-purpose counter/timebase for dividers, timers and sequencers in the project.

---
 rtl/universal_counter_param.sv | 73 +++++++
 tb/tb_universal_counter_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/universal_counter_param.sv
// Parametrised up/down modulo counter with clear, clamped load, tick flags and wrap pulse; UNIVERSAL_COUNTER_SATURATE_EN turns wrap-around into saturation.
// Latency: one clock from sampled control to q/wrap; no backpressure, the counter accepts a control set every cycle.
module universal_counter_param #(
    parameter int unsigned     WIDTH = 16,
    parameter longint unsigned MOD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             syn_clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             max_tick,
    output logic             min_tick,
    output logic             wrap
);

    // Computed in 64 bits so MOD == 2^32 with WIDTH == 32 stays exact.
    localparam logic [63:0]      TOP_L = (MOD == 64'd0) ? ((64'd1 << WIDTH) - 64'd1) : (MOD - 64'd1);
    localparam logic [WIDTH-1:0] TOP   = TOP_L[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             at_top, at_zero;

    assign at_top  = (cnt_q == TOP);
    assign at_zero = (cnt_q == '0);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (syn_clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = (d > TOP) ? TOP : d;
        end else if (en) begin
            if (up) begin
`ifdef UNIVERSAL_COUNTER_SATURATE_EN
                cnt_d = at_top ? TOP : (cnt_q + ONE);
`else
                cnt_d  = at_top ? '0 : (cnt_q + ONE);
                wrap_d = at_top;
`endif
            end else begin
`ifdef UNIVERSAL_COUNTER_SATURATE_EN
                cnt_d = at_zero ? '0 : (cnt_q - ONE);
`else
                cnt_d  = at_zero ? TOP : (cnt_q - ONE);
                wrap_d = at_zero;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign q        = cnt_q;
    assign wrap     = wrap_q;
    assign max_tick = at_top;
    assign min_tick = at_zero;

endmodule

// File: tb/tb_universal_counter_param.sv
// Directed bench: four counter instances (4-bit full, 4-bit mod-10, 8-bit, 16-bit) exercised scenario by scenario.
module tb_universal_counter_param;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // a: WIDTH=4 MOD=0
    logic       en_a, up_a, clr_a, ld_a, mx_a, mn_a, wr_a;
    logic [3:0] d_a, q_a;
    // b: WIDTH=4 MOD=10
    logic       en_b, up_b, clr_b, ld_b, mx_b, mn_b, wr_b;
    logic [3:0] d_b, q_b;
    // c: WIDTH=8 MOD=0
    logic       en_c, up_c, clr_c, ld_c, mx_c, mn_c, wr_c;
    logic [7:0] d_c, q_c;
    // e: WIDTH=16 MOD=0
    logic        en_e, up_e, clr_e, ld_e, mx_e, mn_e, wr_e;
    logic [15:0] d_e, q_e;

    universal_counter_param #(.WIDTH(4), .MOD(0)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .up(up_a), .syn_clr(clr_a), .load(ld_a), .d(d_a),
        .q(q_a), .max_tick(mx_a), .min_tick(mn_a), .wrap(wr_a));
    universal_counter_param #(.WIDTH(4), .MOD(10)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .up(up_b), .syn_clr(clr_b), .load(ld_b), .d(d_b),
        .q(q_b), .max_tick(mx_b), .min_tick(mn_b), .wrap(wr_b));
    universal_counter_param #(.WIDTH(8), .MOD(0)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .up(up_c), .syn_clr(clr_c), .load(ld_c), .d(d_c),
        .q(q_c), .max_tick(mx_c), .min_tick(mn_c), .wrap(wr_c));
    universal_counter_param #(.WIDTH(16), .MOD(0)) u_e (
        .clk(clk), .rst(rst), .en(en_e), .up(up_e), .syn_clr(clr_e), .load(ld_e), .d(d_e),
        .q(q_e), .max_tick(mx_e), .min_tick(mn_e), .wrap(wr_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        en_a = 1'b1; up_a = 1'b1;
        repeat (3) tick();
        checks++; if (q_a !== 4'd0)  begin errors++; $display("FAIL reset_q_a got %0d want 0", q_a); end
        checks++; if (wr_a !== 1'b0) begin errors++; $display("FAIL reset_wrap_a got %b want 0", wr_a); end
        checks++; if (mn_a !== 1'b1) begin errors++; $display("FAIL reset_min_a got %b want 1", mn_a); end
        checks++; if (mx_a !== 1'b0) begin errors++; $display("FAIL reset_max_a got %b want 0", mx_a); end
        checks++; if (q_e !== 16'd0) begin errors++; $display("FAIL reset_q_e got %h want 0000", q_e); end
        rst = 1'b1;
        checks++; if (q_a !== 4'd0)  begin errors++; $display("FAIL release_q_a got %0d want 0", q_a); end
    endtask

    task automatic test_up_count();
        logic [3:0] exp_q;
        for (int i = 0; i < 17; i++) begin
            tick();
            exp_q = 4'((i + 1) % 16);
            checks++; if (q_a !== exp_q) begin errors++; $display("FAIL up_q step %0d got %0d want %0d", i, q_a, exp_q); end
            checks++; if (wr_a !== (i == 15)) begin errors++; $display("FAIL up_wrap step %0d got %b want %b", i, wr_a, (i == 15)); end
            checks++; if (mx_a !== (exp_q == 4'd15)) begin errors++; $display("FAIL up_max step %0d got %b want %b", i, mx_a, (exp_q == 4'd15)); end
        end
        en_a = 1'b0;
    endtask

    task automatic test_mod_down();
        logic [3:0] exp_q;
        en_b = 1'b1; up_b = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            exp_q = (i <= 9) ? 4'(9 - i) : 4'd9;
            checks++; if (q_b !== exp_q) begin errors++; $display("FAIL down_q step %0d got %0d want %0d", i, q_b, exp_q); end
            checks++; if (wr_b !== (i == 0 || i == 10)) begin errors++; $display("FAIL down_wrap step %0d got %b want %b", i, wr_b, (i == 0 || i == 10)); end
            checks++; if (mn_b !== (exp_q == 4'd0)) begin errors++; $display("FAIL down_min step %0d got %b want %b", i, mn_b, (exp_q == 4'd0)); end
            checks++; if (mx_b !== (exp_q == 4'd9)) begin errors++; $display("FAIL down_max step %0d got %b want %b", i, mx_b, (exp_q == 4'd9)); end
        end
        en_b = 1'b0;
    endtask

    task automatic test_priority();
        ld_c = 1'b1; d_c = 8'h20;
        tick();
        checks++; if (q_c !== 8'h20) begin errors++; $display("FAIL prio_preload got %h want 20", q_c); end
        clr_c = 1'b1; ld_c = 1'b1; d_c = 8'h55; en_c = 1'b1; up_c = 1'b1;
        tick();
        checks++; if (q_c !== 8'h00) begin errors++; $display("FAIL prio_clr got %h want 00", q_c); end
        checks++; if (wr_c !== 1'b0) begin errors++; $display("FAIL prio_clr_wrap got %b want 0", wr_c); end
        clr_c = 1'b0; en_c = 1'b0;
        tick();
        checks++; if (q_c !== 8'h55) begin errors++; $display("FAIL prio_load got %h want 55", q_c); end
        ld_c = 1'b0; up_c = 1'b0;
        tick();
        checks++; if (q_c !== 8'h55) begin errors++; $display("FAIL prio_hold got %h want 55", q_c); end
        ld_c = 1'b1; d_c = 8'hFF; en_c = 1'b1; up_c = 1'b0;
        tick();
        checks++; if (q_c !== 8'hFF) begin errors++; $display("FAIL prio_load_over_en got %h want ff", q_c); end
        checks++; if (mx_c !== 1'b1) begin errors++; $display("FAIL prio_max got %b want 1", mx_c); end
        ld_c = 1'b0; up_c = 1'b1;
        tick();
`ifdef UNIVERSAL_COUNTER_SATURATE_EN
        checks++; if (q_c !== 8'hFF) begin errors++; $display("FAIL prio_top_up got %h want ff", q_c); end
        checks++; if (wr_c !== 1'b0) begin errors++; $display("FAIL prio_top_wrap got %b want 0", wr_c); end
`else
        checks++; if (q_c !== 8'h00) begin errors++; $display("FAIL prio_top_up got %h want 00", q_c); end
        checks++; if (wr_c !== 1'b1) begin errors++; $display("FAIL prio_top_wrap got %b want 1", wr_c); end
`endif
        en_c = 1'b0;
    endtask

    task automatic test_load_clamp();
        ld_b = 1'b1; d_b = 4'd13;
        tick();
        checks++; if (q_b !== 4'd9)  begin errors++; $display("FAIL clamp13_q got %0d want 9", q_b); end
        checks++; if (mx_b !== 1'b1) begin errors++; $display("FAIL clamp13_max got %b want 1", mx_b); end
        d_b = 4'd4;
        tick();
        checks++; if (q_b !== 4'd4)  begin errors++; $display("FAIL load4_q got %0d want 4", q_b); end
        d_b = 4'd10;
        tick();
        checks++; if (q_b !== 4'd9)  begin errors++; $display("FAIL clamp10_q got %0d want 9", q_b); end
        ld_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
        tick();
`ifdef UNIVERSAL_COUNTER_SATURATE_EN
        checks++; if (q_b !== 4'd9)  begin errors++; $display("FAIL clamp_up_q got %0d want 9", q_b); end
        checks++; if (wr_b !== 1'b0) begin errors++; $display("FAIL clamp_up_wrap got %b want 0", wr_b); end
`else
        checks++; if (q_b !== 4'd0)  begin errors++; $display("FAIL clamp_up_q got %0d want 0", q_b); end
        checks++; if (wr_b !== 1'b1) begin errors++; $display("FAIL clamp_up_wrap got %b want 1", wr_b); end
`endif
        en_b = 1'b0;
        tick();
        checks++; if (wr_b !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle got %b want 0", wr_b); end
    endtask

`ifdef UNIVERSAL_COUNTER_SATURATE_EN
    task automatic test_saturate();
        logic [3:0] exp_up [4];
        exp_up = '{4'd15, 4'd15, 4'd15, 4'd15};
        ld_a = 1'b1; d_a = 4'd14;
        tick();
        ld_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (q_a !== exp_up[i]) begin errors++; $display("FAIL sat_up step %0d got %0d want %0d", i, q_a, exp_up[i]); end
            checks++; if (wr_a !== 1'b0) begin errors++; $display("FAIL sat_up_wrap step %0d got %b want 0", i, wr_a); end
        end
        en_a = 1'b0; ld_a = 1'b1; d_a = 4'd1;
        tick();
        ld_a = 1'b0; en_a = 1'b1; up_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (q_a !== 4'd0) begin errors++; $display("FAIL sat_down step %0d got %0d want 0", i, q_a); end
            checks++; if (wr_a !== 1'b0) begin errors++; $display("FAIL sat_down_wrap step %0d got %b want 0", i, wr_a); end
        end
        en_a = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        ld_e = 1'b1; d_e = 16'h1230;
        tick();
        ld_e = 1'b0; en_e = 1'b1; up_e = 1'b1;
        repeat (4) tick();
        checks++; if (q_e !== 16'h1234) begin errors++; $display("FAIL async_pre got %h want 1234", q_e); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (q_e !== 16'h0000) begin errors++; $display("FAIL async_q got %h want 0000", q_e); end
        checks++; if (wr_e !== 1'b0)    begin errors++; $display("FAIL async_wrap got %b want 0", wr_e); end
        checks++; if (mn_e !== 1'b1)    begin errors++; $display("FAIL async_min got %b want 1", mn_e); end
        tick();
        checks++; if (q_e !== 16'h0000) begin errors++; $display("FAIL async_hold got %h want 0000", q_e); end
        rst = 1'b1;
        tick();
        checks++; if (q_e !== 16'h0001) begin errors++; $display("FAIL async_resume1 got %h want 0001", q_e); end
        tick();
        checks++; if (q_e !== 16'h0002) begin errors++; $display("FAIL async_resume2 got %h want 0002", q_e); end
        en_e = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        {en_a, up_a, clr_a, ld_a} = '0; d_a = '0;
        {en_b, up_b, clr_b, ld_b} = '0; d_b = '0;
        {en_c, up_c, clr_c, ld_c} = '0; d_c = '0;
        {en_e, up_e, clr_e, ld_e} = '0; d_e = '0;
        #1;
        test_reset();
`ifdef UNIVERSAL_COUNTER_SATURATE_EN
        en_a = 1'b0;
        test_saturate();
`else
        test_up_count();
        test_mod_down();
`endif
        test_priority();
        test_load_clamp();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
